// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue: fetches two words per cycle into a circular
// buffer of {PC, instruction} entries and presents the two oldest to decode.
module fetch_queue #(
  parameter int                 D_WIDTH  = 32,
  parameter int                 DEPTH    = 8,
  parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_Redirect,
  input  logic [D_WIDTH-1:0]         i_RedirectPC,
  output logic [D_WIDTH-1:0]         o_FetchPC,
  input  logic [D_WIDTH-1:0]         i_Instruction1,
  input  logic [D_WIDTH-1:0]         i_Instruction2,
  input  logic                       i_Deq1,
  input  logic                       i_Deq2,
  output logic [D_WIDTH-1:0]         o_PC1,
  output logic [D_WIDTH-1:0]         o_Instruction1,
  output logic [D_WIDTH-1:0]         o_PC2,
  output logic [D_WIDTH-1:0]         o_Instruction2,
  output logic                       o_Valid1,
  output logic                       o_Valid2,
  output logic [$clog2(DEPTH):0]     o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      rptr_reg, wptr_reg;
  logic [AW-1:0]      rptr_plus1, wptr_plus1;
  logic [CW-1:0]      count_reg, count_next;
  logic [D_WIDTH-1:0] pc_reg, pc_next;
  logic [D_WIDTH-1:0] pc_mem    [DEPTH];
  logic [D_WIDTH-1:0] instr_mem [DEPTH];
  logic               enq;
  logic [1:0]         deq_amt;
  logic               valid1, valid2;

  assign rptr_plus1 = rptr_reg + AW'(1);
  assign wptr_plus1 = wptr_reg + AW'(1);
  assign valid1     = (count_reg >= CW'(1));
  assign valid2     = (count_reg >= CW'(2));

  // Enqueue decision uses start-of-cycle occupancy only, so a same-cycle
  // dequeue never opens room for a fetch.
  always_comb begin
    enq        = 1'b0;
    deq_amt    = 2'd0;
    count_next = count_reg;
    pc_next    = pc_reg;
    if (i_Redirect) begin
      count_next = '0;
      pc_next    = {i_RedirectPC[D_WIDTH-1:2], 2'b00};
    end else begin
      enq = (count_reg <= CW'(DEPTH - 2));
      if (i_Deq1 && i_Deq2 && valid2)
        deq_amt = 2'd2;
      else if (i_Deq1 && valid1)
        deq_amt = 2'd1;
      count_next = count_reg + (enq ? CW'(2) : CW'(0)) - CW'(deq_amt);
      if (enq)
        pc_next = pc_reg + D_WIDTH'(8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      rptr_reg  <= '0;
      wptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      if (i_Redirect) begin
        rptr_reg <= '0;
        wptr_reg <= '0;
      end else begin
        rptr_reg <= rptr_reg + AW'(deq_amt);
        if (enq)
          wptr_reg <= wptr_reg + AW'(2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (enq) begin
      pc_mem[wptr_reg]      <= pc_reg;
      instr_mem[wptr_reg]   <= i_Instruction1;
      pc_mem[wptr_plus1]    <= pc_reg + D_WIDTH'(4);
      instr_mem[wptr_plus1] <= i_Instruction2;
    end
  end

  assign o_FetchPC      = pc_reg;
  assign o_Count        = count_reg;
  assign o_Valid1       = valid1;
  assign o_Valid2       = valid2;
  assign o_PC1          = valid1 ? pc_mem[rptr_reg]      : '0;
  assign o_Instruction1 = valid1 ? instr_mem[rptr_reg]   : '0;
  assign o_PC2          = valid2 ? pc_mem[rptr_plus1]    : '0;
  assign o_Instruction2 = valid2 ? instr_mem[rptr_plus1] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based program-order model.
module tb_fetch_queue;

  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic [31:0] o_FetchPC;
  logic [31:0] i_Instruction1, i_Instruction2;
  logic        i_Deq1, i_Deq2;
  logic [31:0] o_PC1, o_Instruction1, o_PC2, o_Instruction2;
  logic        o_Valid1, o_Valid2;
  logic [3:0]  o_Count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] m_pc;
  logic [31:0] mq_pc[$];
  logic [31:0] mq_in[$];

  fetch_queue #(.D_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_Redirect(i_Redirect), .i_RedirectPC(i_RedirectPC),
    .o_FetchPC(o_FetchPC),
    .i_Instruction1(i_Instruction1), .i_Instruction2(i_Instruction2),
    .i_Deq1(i_Deq1), .i_Deq2(i_Deq2),
    .o_PC1(o_PC1), .o_Instruction1(o_Instruction1),
    .o_PC2(o_PC2), .o_Instruction2(o_Instruction2),
    .o_Valid1(o_Valid1), .o_Valid2(o_Valid2),
    .o_Count(o_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign i_Instruction1 = mem_word(o_FetchPC);
  assign i_Instruction2 = mem_word(o_FetchPC + 32'd4);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = mq_pc.size();
    check("count",   32'(o_Count), 32'(n));
    check("fetchpc", o_FetchPC, m_pc);
    check("valid1",  32'(o_Valid1), 32'(n >= 1));
    check("valid2",  32'(o_Valid2), 32'(n >= 2));
    check("pc1",     o_PC1,          (n >= 1) ? mq_pc[0] : 32'h0);
    check("instr1",  o_Instruction1, (n >= 1) ? mq_in[0] : 32'h0);
    check("pc2",     o_PC2,          (n >= 2) ? mq_pc[1] : 32'h0);
    check("instr2",  o_Instruction2, (n >= 2) ? mq_in[1] : 32'h0);
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_in.delete();
    m_pc = RESET_PC;
  endtask

  // Applies one cycle's inputs (caller is at a negedge), advances the model,
  // crosses the rising edge and compares at the following negedge.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit d1, input bit d2);
    int n;
    int deq;
    bit enq;
    i_Redirect   = redir;
    i_RedirectPC = rpc;
    i_Deq1       = d1;
    i_Deq2       = d2;
    n = mq_pc.size();
    if (redir) begin
      mq_pc.delete();
      mq_in.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      enq = (n <= DEPTH - 2);
      deq = (d1 && d2 && n >= 2) ? 2 : ((d1 && n >= 1) ? 1 : 0);
      for (int k = 0; k < deq; k++) begin
        void'(mq_pc.pop_front());
        void'(mq_in.pop_front());
      end
      if (enq) begin
        mq_pc.push_back(m_pc);
        mq_in.push_back(mem_word(m_pc));
        mq_pc.push_back(m_pc + 32'd4);
        mq_in.push_back(mem_word(m_pc + 32'd4));
        m_pc = m_pc + 32'd8;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    $display("cyc %0d redir=%0b rpc=%h d1=%0b d2=%0b count=%0d fetchpc=%h pc1=%h pc2=%h",
             cyc, redir, rpc, d1, d2, o_Count, o_FetchPC, o_PC1, o_PC2);
    check_all();
  endtask

  initial begin
    int bias;
    rst_n        = 1'b0;
    i_Redirect   = 1'b0;
    i_RedirectPC = 32'h0;
    i_Deq1       = 1'b0;
    i_Deq2       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Fill with no dequeue, then hold while full.
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
    // Drain two per cycle from full.
    for (int k = 0; k < 5; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
    // Redirect from full with a dequeue request on the same cycle.
    step(1'b1, 32'h0000_0103, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Asynchronous reset between edges with six entries held.
    step(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_count", 32'(o_Count), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic with a drifting dequeue bias.
    bias = 2;
    for (int k = 0; k < 300; k++) begin
      logic [31:0] rpc;
      if (k % 50 == 0) bias = $urandom_range(0, 3);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31))) : $urandom;
      step(($urandom_range(0, 15) == 0), rpc,
           ($urandom_range(0, 3) < bias + 1), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter D_WIDTH, default `D_WIDTH from param.v (32), data/address width.
REQ-002 Parameter DEPTH, default 8, entry count; power of 2, >= 4.
REQ-003 Parameter RESET_PC, default 32'h0, fetch PC after reset.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_Redirect  input  1  branch/jump redirect; flushes queue, reloads fetch PC.
REQ-007 i_RedirectPC  input  D_WIDTH  redirect target.
REQ-008 o_FetchPC  output  D_WIDTH  instruction-memory address of current fetch pair.
REQ-009 i_Instruction1  input  D_WIDTH  memory word at o_FetchPC, same cycle (combinational memory).
REQ-010 i_Instruction2  input  D_WIDTH  memory word at o_FetchPC+4, same cycle.
REQ-011 i_Deq1  input  1  decode consumes slot 1.
REQ-012 i_Deq2  input  1  decode consumes slot 2; meaningful only with i_Deq1.
REQ-013 o_PC1, o_Instruction1  output  D_WIDTH each  head entry PC and instruction.
REQ-014 o_PC2, o_Instruction2  output  D_WIDTH each  head+1 entry PC and instruction.
REQ-015 o_Valid1, o_Valid2  output  1 each  slot 1 / slot 2 holds a valid entry.
REQ-016 o_Count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-017 Storage: circular buffer of DEPTH {PC, instruction} entries, read and write pointers wrap modulo DEPTH.
REQ-018 Fetch PC register pc drives o_FetchPC; bits [1:0] always 0.
REQ-019 Enqueue condition: i_Redirect=0 and start-of-cycle count <= DEPTH-2; no bypass from same-cycle dequeue.
REQ-020 On enqueue: write {pc, i_Instruction1} at wptr, {pc+4, i_Instruction2} at wptr+1; wptr += 2; pc <= pc+8.
REQ-021 No enqueue: pc, wptr unchanged (pc held while queue nearly full).
REQ-022 Dequeue amount: 2 if i_Deq1&i_Deq2&o_Valid2; else 1 if i_Deq1&o_Valid1; else 0; i_Deq2 without i_Deq1 dequeues nothing.
REQ-023 rptr advances by dequeue amount; count <= count + 2*enq - deq, never exceeds DEPTH nor underflows.
REQ-024 o_Valid1 = (count>=1); o_Valid2 = (count>=2); combinational from registered state.
REQ-025 Slot outputs combinational from storage at rptr / rptr+1; forced to 0 when corresponding valid is 0.
REQ-026 Redirect: next cycle count=0, rptr=wptr=0, pc <= {i_RedirectPC[D_WIDTH-1:2],2'b00}; same-cycle enqueue and dequeue suppressed.
REQ-027 Redirect takes priority over all other same-cycle events.
REQ-028 PC arithmetic modulo 2^D_WIDTH; pc+8 wraps 32'hFFFF_FFF8 -> 32'h0.
REQ-029 Queue order strictly in program order; slot 1 always older than slot 2.

Reset
REQ-030 rst_n low: immediately pc=RESET_PC, rptr=wptr=0, count=0; storage cleared to 0.
REQ-031 Reset outputs: o_FetchPC=RESET_PC, o_Valid1=o_Valid2=0, all PC/instruction outputs 0, o_Count=0.
REQ-032 Reset asserted mid-operation discards all entries and any pending redirect; first enqueue occurs on first rising edge after rst_n high.

Verification
REQ-033 Reset release, memory returns A,B -> after 1 edge: o_Valid1=o_Valid2=1, o_PC1=0/A, o_PC2=4/B, o_FetchPC=8, o_Count=2.
REQ-034 No dequeue, DEPTH=8 -> after 4 edges o_Count=8, o_FetchPC=0x20 held constant thereafter.
REQ-035 Full queue, i_Deq1=i_Deq2=1 every cycle -> count 8,6,6,6...; o_PC1 sequence 0x00,0x08,0x10,...; no enqueue on first dequeue cycle.
REQ-036 Full queue, i_Redirect=1, i_RedirectPC=0x103, i_Deq1=1 -> next cycle o_Count=0, valids 0, o_FetchPC=0x100; following cycle o_PC1=0x100, o_PC2=0x104.
REQ-037 Count=1, i_Deq1=i_Deq2=1 -> dequeue 1 only; i_Deq2=1,i_Deq1=0 -> no dequeue; count never negative.
REQ-038 rst_n dropped asynchronously between edges with count=6 -> outputs zero and o_FetchPC=RESET_PC before next edge.
